// File: rtl/jump_ctrl.sv
// Player-input stage for the LED-matrix jump game: button synchroniser and
// debouncer feeding a tick-paced jump state machine with a saturating jump counter.
module jump_ctrl #(
  parameter int DB_CYCLES  = 20000,
  parameter int AIR_TICKS  = 6,
  parameter int COOL_TICKS = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             tick,
  input  logic             col,
  output logic             up,
  output logic             dead,
  output logic             btn_press,
  output logic [CNT_W-1:0] jump_cnt
);

  localparam int DB_W   = (DB_CYCLES  > 1) ? $clog2(DB_CYCLES)  : 1;
  localparam int AIR_W  = (AIR_TICKS  > 1) ? $clog2(AIR_TICKS)  : 1;
  localparam int COOL_W = (COOL_TICKS > 1) ? $clog2(COOL_TICKS) : 1;
  localparam int COOL_INIT = (COOL_TICKS > 0) ? COOL_TICKS - 1 : 0;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_COOL   = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_lvl_q, db_lvl_d;
  logic              btn_press_q, btn_press_d;
  logic              db_flip_s;

  state_t            state_q, state_d;
  logic [AIR_W-1:0]  air_cnt_q, air_cnt_d;
  logic [COOL_W-1:0] cool_cnt_q, cool_cnt_d;
  logic [CNT_W-1:0]  jump_cnt_q, jump_cnt_d;
  logic              pending_q, pending_d;
  logic              up_q, up_d;
  logic              dead_q, dead_d;

  // Input path: two-stage synchroniser and stability counter.
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    db_cnt_d    = db_cnt_q;
    db_lvl_d    = db_lvl_q;
    db_flip_s   = 1'b0;
    if (sync2_q == db_lvl_q) begin
      db_cnt_d = {DB_W{1'b0}};
    end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
      db_cnt_d  = {DB_W{1'b0}};
      db_lvl_d  = sync2_q;
      db_flip_s = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
    btn_press_d = db_flip_s & ~db_lvl_q;
  end

  // Input path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= {DB_W{1'b0}};
      db_lvl_q    <= 1'b0;
      btn_press_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      db_lvl_q    <= db_lvl_d;
      btn_press_q <= btn_press_d;
    end
  end

  // Jump FSM next state; collision overrides tick and press in every state.
  always_comb begin
    state_d    = state_q;
    air_cnt_d  = air_cnt_q;
    cool_cnt_d = cool_cnt_q;
    jump_cnt_d = jump_cnt_q;
    pending_d  = pending_q | (btn_press_q & (state_q == ST_GROUND));
    if (col) begin
      state_d   = ST_DEAD;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_GROUND: begin
          if (tick && (pending_q || btn_press_q)) begin
            state_d   = ST_AIR;
            air_cnt_d = AIR_W'(AIR_TICKS - 1);
            pending_d = 1'b0;
            if (jump_cnt_q == {CNT_W{1'b1}}) begin
              jump_cnt_d = jump_cnt_q;
            end else begin
              jump_cnt_d = jump_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_GROUND;
          end
        end
        ST_AIR: begin
          if (!tick) begin
            state_d = ST_AIR;
          end else if (air_cnt_q != {AIR_W{1'b0}}) begin
            air_cnt_d = air_cnt_q - AIR_W'(1);
          end else if (COOL_TICKS == 0) begin
            state_d = ST_GROUND;
          end else begin
            state_d    = ST_COOL;
            cool_cnt_d = COOL_W'(COOL_INIT);
          end
        end
        ST_COOL: begin
          if (!tick) begin
            state_d = ST_COOL;
          end else if (cool_cnt_q == {COOL_W{1'b0}}) begin
            state_d = ST_GROUND;
          end else begin
            cool_cnt_d = cool_cnt_q - COOL_W'(1);
          end
        end
        ST_DEAD: begin
          if (btn_press_q) begin
            state_d    = ST_GROUND;
            jump_cnt_d = {CNT_W{1'b0}};
            pending_d  = 1'b0;
            air_cnt_d  = {AIR_W{1'b0}};
            cool_cnt_d = {COOL_W{1'b0}};
          end else begin
            state_d = ST_DEAD;
          end
        end
        default: begin
          state_d   = ST_GROUND;
          pending_d = 1'b0;
        end
      endcase
    end
    // Outputs decoded from the next state so they leave straight from flops.
    up_d   = (state_d == ST_AIR);
    dead_d = (state_d == ST_DEAD);
  end

  // Jump FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_GROUND;
      air_cnt_q  <= {AIR_W{1'b0}};
      cool_cnt_q <= {COOL_W{1'b0}};
      jump_cnt_q <= {CNT_W{1'b0}};
      pending_q  <= 1'b0;
      up_q       <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      air_cnt_q  <= air_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      jump_cnt_q <= jump_cnt_d;
      pending_q  <= pending_d;
      up_q       <= up_d;
      dead_q     <= dead_d;
    end
  end

  assign up        = up_q;
  assign dead      = dead_q;
  assign btn_press = btn_press_q;
  assign jump_cnt  = jump_cnt_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl with DB_CYCLES=4, AIR_TICKS=3, COOL_TICKS=1, CNT_W=2.
module tb_jump_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       tick;
  logic       col;
  logic       up;
  logic       dead;
  logic       btn_press;
  logic [1:0] jump_cnt;

  int n_cmp;
  int n_mis;

  jump_ctrl #(
    .DB_CYCLES (4),
    .AIR_TICKS (3),
    .COOL_TICKS(1),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .tick     (tick),
    .col      (col),
    .up       (up),
    .dead     (dead),
    .btn_press(btn_press),
    .jump_cnt (jump_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs_v, exp_v);
    end
  endtask

  // One-clk game tick, driven and sampled on falling edges.
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Clean press and release; must yield exactly one btn_press pulse.
  task automatic press(input string tag);
    int pulses;
    pulses  = 0;
    btn_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (btn_press) pulses++;
    end
    btn_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (btn_press) pulses++;
    end
    check_val(tag, 32'(pulses), 32'd1);
  endtask

  initial begin
    int pulses;
    int first;
    n_cmp   = 0;
    n_mis   = 0;
    rst     = 1'b0;
    btn_raw = 1'b0;
    tick    = 1'b0;
    col     = 1'b0;

    // Reset state, including a tick while held in reset.
    repeat (2) @(negedge clk);
    do_tick();
    check_val("rst_up", 32'(up), 32'd0);
    check_val("rst_dead", 32'(dead), 32'd0);
    check_val("rst_press", 32'(btn_press), 32'd0);
    check_val("rst_cnt", 32'(jump_cnt), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: bouncy press then bouncy release.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      repeat (2) begin
        @(negedge clk);
        if (btn_press) pulses++;
      end
    end
    check_val("bounce_no_early", 32'(pulses), 32'd0);
    btn_raw = 1'b1;
    pulses  = 0;
    first   = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (btn_press) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check_val("bounce_one_press", 32'(pulses), 32'd1);
    check_val("bounce_latency", 32'(first >= 5 && first <= 7), 32'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      repeat (2) begin
        @(negedge clk);
        if (btn_press) pulses++;
      end
    end
    btn_raw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (btn_press) pulses++;
    end
    check_val("bounce_release", 32'(pulses), 32'd0);

    // 2: basic jump timing.
    press("j2_press");
    check_val("j2_up_wait", 32'(up), 32'd0);
    do_tick();
    check_val("j2_up_rise", 32'(up), 32'd1);
    check_val("j2_cnt", 32'(jump_cnt), 32'd1);
    repeat (3) @(negedge clk);
    check_val("j2_up_hold", 32'(up), 32'd1);
    do_tick();
    do_tick();
    check_val("j2_up_t2", 32'(up), 32'd1);
    do_tick();
    check_val("j2_up_fall", 32'(up), 32'd0);
    do_tick();
    do_tick();
    check_val("j2_ground_idle", 32'(up), 32'd0);

    // 3: presses in AIR and COOL are dropped.
    press("j3_press_a");
    do_tick();
    check_val("j3_up", 32'(up), 32'd1);
    check_val("j3_cnt2", 32'(jump_cnt), 32'd2);
    press("j3_press_air");
    check_val("j3_air_hold", 32'(up), 32'd1);
    do_tick();
    do_tick();
    do_tick();
    check_val("j3_cool", 32'(up), 32'd0);
    press("j3_press_cool");
    do_tick();
    do_tick();
    check_val("j3_dropped_up", 32'(up), 32'd0);
    check_val("j3_dropped_cnt", 32'(jump_cnt), 32'd2);
    press("j3_press_b");
    do_tick();
    check_val("j3_relaunch", 32'(up), 32'd1);
    check_val("j3_cnt3", 32'(jump_cnt), 32'd3);
    repeat (4) do_tick();

    // 4: collision freeze and restart.
    press("j4_press");
    do_tick();
    check_val("j4_up", 32'(up), 32'd1);
    check_val("j4_cnt_sat", 32'(jump_cnt), 32'd3);
    do_tick();
    col  = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_val("j4_col_up", 32'(up), 32'd0);
    check_val("j4_col_dead", 32'(dead), 32'd1);
    do_tick();
    do_tick();
    check_val("j4_tick_ign", 32'(dead), 32'd1);
    press("j4_press_col");
    check_val("j4_press_col_dead", 32'(dead), 32'd1);
    check_val("j4_press_col_cnt", 32'(jump_cnt), 32'd3);
    col = 1'b0;
    do_tick();
    check_val("j4_still_dead", 32'(dead), 32'd1);
    check_val("j4_dead_up", 32'(up), 32'd0);
    press("j4_restart");
    check_val("j4_alive", 32'(dead), 32'd0);
    check_val("j4_cnt_clr", 32'(jump_cnt), 32'd0);
    do_tick();
    check_val("j4_no_pending", 32'(up), 32'd0);

    // 5: counter saturation over five jumps.
    for (int j = 1; j <= 5; j++) begin
      press("j5_press");
      do_tick();
      check_val("j5_up", 32'(up), 32'd1);
      check_val("j5_cnt", 32'(jump_cnt), 32'((j < 3) ? j : 3));
      repeat (3) do_tick();
      check_val("j5_land", 32'(up), 32'd0);
      do_tick();
    end

    // 6: asynchronous reset mid-jump.
    press("j6_press");
    do_tick();
    check_val("j6_up", 32'(up), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("j6_rst_up", 32'(up), 32'd0);
    check_val("j6_rst_cnt", 32'(jump_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_tick();
    check_val("j6_no_jump", 32'(up), 32'd0);
    check_val("j6_dead", 32'(dead), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
